msk_shares_serializer: RTL and testbench
========================================

# msk_shares_serializer

Output-side counterpart of the masked key holder's word-serial fetch path. It captures one masked block of `d` shares from the core in a single cycle, as the shared bus. It then streams the shares out one `WORD`-bit word per handshake over a valid/ready bus, in share-major order. The block sits between the masked AES core output and the top-level data-out interface. It zeroes its holding register once a block has been fully transmitted, so no residual shares remain.

## Interface
- `d`, default 2: number of shares.
- `BITS`, default 128: bits per share. Must be a multiple of `WORD`; elaboration fails otherwise.
- `WORD`, default 32: output word width.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `sh_data_in` input `d*BITS`: shared bus, bit-interleaved; bit `j` of share `i` is at index `j*d+i`.
- `in_valid` input 1: `sh_data_in` is valid.
- `in_ready` output 1: block accepts a new input block.
- `data_out` output `WORD`: current output word.
- `out_valid` output 1: `data_out` is valid.
- `out_ready` input 1: downstream consumes `data_out`.
- `out_last` output 1: the current word is the final word of the block.
- `busy` output 1: a block is held or being transmitted.

## Operation
- Derived constants:
  - `NW = BITS/WORD` (words per share).
  - `NT = d*NW` (words per block).
  - Counters `word_idx` (`$clog2(NW)` bits, minimum 1) and `share_idx` (`$clog2(d)` bits, minimum 1).
- Holding register: `d*BITS` bits, stored share-major (decoded from the interleaved bus at capture), so share `i` occupies `[i*BITS +: BITS]`.
- Word order:
  - share 0 word 0 first, i.e. share 0 bits `[WORD-1:0]`, then share 0 bits `[2*WORD-1:WORD]`, … up to share 0 word `NW-1`;
  - then share 1 word 0, and so on up to share `d-1` word `NW-1`.
- `data_out` = holding register `[(share_idx*BITS + word_idx*WORD) +: WORD]`, combinational from registers.
- State `IDLE`:
  - `in_ready=1`, `out_valid=0`, `busy=0`.
  - On `in_valid`: capture, reset both counters, go to `SEND`.
- State `SEND`:
  - `out_valid=1`, `busy=1`.
  - `out_last = (share_idx==d-1) & (word_idx==NW-1)`.
  - On `out_valid & out_ready`:
    - if `word_idx==NW-1`: `word_idx` wraps to 0 and `share_idx` increments;
    - otherwise `word_idx` increments.
  - On a handshake with `out_last`:
    - if `in_valid` is also high (the back-to-back case, since `in_ready=1` this cycle): capture the new block, reset the counters, stay in `SEND`;
    - otherwise: clear the holding register to zero, reset the counters, go to `IDLE`.
- `in_ready = (state==IDLE) | (state==SEND & out_last & out_ready)`. The `in_ready` output is combinational from `out_ready`.
- `in_valid` in `SEND` without the last handshake is ignored: no capture, and `in_ready=0`.
- `out_valid` never drops before its handshake. `data_out` and `out_last` stay stable while `out_valid & ~out_ready`.

## Timing
- Reset values (the cycle after `rst`, and while `rst` is held):
  - state `IDLE`, counters 0, holding register 0;
  - `out_valid=0`, `out_last=0`, `busy=0`, `in_ready=1`, `data_out=0`.
- Capture latency: if `in_valid & in_ready` at edge t, then `out_valid=1` from cycle t+1, presenting share 0 word 0.
- Throughput: one word per cycle while `out_ready=1`. A block takes `NT` cycles (8 for the defaults).
- With `in_valid` held high continuously, back-to-back blocks stream with no idle cycle.
- `rst` mid-transfer: the block is aborted, the register is zeroed, and `out_valid=0` on the next cycle. No partial resume.
- Stalls of any length (`out_ready=0`) leave all state unchanged.

## Test plan
- Single block, `out_ready=1`. Shares: s0 = 0x00112233_44556677_8899aabb_ccddeeff, s1 = 0xfedcba98_76543210_0f1e2d3c_4b5a6978, both interleaved onto `sh_data_in`.
  - Required words: 0xccddeeff, 0x8899aabb, 0x44556677, 0x00112233, 0x4b5a6978, 0x0f1e2d3c, 0x76543210, 0xfedcba98.
  - `out_last` only on the 8th word; `busy` falls after the 8th word.
- Backpressure: same block, with `out_ready` toggled as 1,0,0,1,… Required: the identical 8-word sequence, with `data_out` and `out_last` stable during every stall.
- Back-to-back: `in_valid` held high with block A, then block B presented. Required: B is captured on A's last handshake, and B's word 0 is valid on the next cycle with no gap. `in_ready` is low on A's other 7 words.
- Ignored input: assert `in_valid` with new data mid-transfer, while `out_ready=0`. Required: the output sequence is unchanged and no capture occurs.
- Clearing: after a single block completes with `in_valid=0`, the holding register reads all-zero internally, and `data_out=0` in `IDLE`.
- Reset mid-operation: assert `rst` after 3 words. Required: `out_valid=0` next cycle, then `in_ready=1`, and a fresh block restarts at share 0 word 0.

Source files
------------

// File: rtl/msk_shares_serializer_if.sv
// Bus bundle between the masked core output, the serializer and the data-out port.
// master: the serializer side (accepts shared blocks, drives the word stream).
// slave: the surrounding environment (presents blocks, consumes words).
interface msk_shares_serializer_if #(
  parameter int d    = 2,
  parameter int BITS = 128,
  parameter int WORD = 32
);
  logic [d*BITS-1:0] sh_data_in;
  logic              in_valid;
  logic              in_ready;
  logic [WORD-1:0]   data_out;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;

  modport master (
    input  sh_data_in, in_valid, out_ready,
    output in_ready, data_out, out_valid, out_last, busy
  );

  modport slave (
    output sh_data_in, in_valid, out_ready,
    input  in_ready, data_out, out_valid, out_last, busy
  );
endinterface

// File: rtl/msk_shares_serializer.sv
// Captures one bit-interleaved masked block and streams it out share-major, one WORD per handshake.
// Latency: first word valid the cycle after capture; one word per cycle while out_ready is high.
// Backpressure: out_ready low freezes all state; a new block is only taken on the last handshake or in IDLE.
module msk_shares_serializer #(
  parameter int d    = 2,
  parameter int BITS = 128,
  parameter int WORD = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  msk_shares_serializer_if.master      bus
);

  localparam int NW  = BITS / WORD;
  localparam int NT  = d * NW;
  localparam int WIW = (NW > 1) ? $clog2(NW) : 1;
  localparam int SIW = (d > 1) ? $clog2(d) : 1;

  // A partial final word would be silently truncated, so refuse to build.
  if ((BITS % WORD) != 0) begin : g_bad_word
    $error("msk_shares_serializer: BITS must be a multiple of WORD");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t            r_state;
  logic [d*BITS-1:0] r_hold;
  logic [WIW-1:0]    r_word_idx;
  logic [SIW-1:0]    r_share_idx;

  logic [d*BITS-1:0] w_decoded;
  logic [WORD-1:0]   w_acc [NT+1];
  logic              w_word_last;
  logic              w_out_last;
  logic              w_in_ready;

  // De-interleave: bus bit j*d+i is bit j of share i; stored share-major.
  for (genvar gi = 0; gi < d; gi++) begin : g_share
    for (genvar gj = 0; gj < BITS; gj++) begin : g_bit
      assign w_decoded[gi*BITS + gj] = bus.sh_data_in[gj*d + gi];
    end
  end

  // Word select as an AND-OR chain over all (share, word) slots.
  assign w_acc[0] = '0;
  for (genvar gs = 0; gs < d; gs++) begin : g_sel_s
    for (genvar gw = 0; gw < NW; gw++) begin : g_sel_w
      localparam int K = gs*NW + gw;
      logic w_hit;
      assign w_hit      = (r_share_idx == SIW'(gs)) && (r_word_idx == WIW'(gw));
      assign w_acc[K+1] = w_acc[K] | (w_hit ? r_hold[gs*BITS + gw*WORD +: WORD] : '0);
    end
  end

  assign w_word_last = (r_word_idx == WIW'(NW-1));
  assign w_out_last  = (r_state == SEND) && w_word_last && (r_share_idx == SIW'(d-1));
  // Back-to-back: the slot frees up in the same cycle the last word is consumed.
  assign w_in_ready  = (r_state == IDLE) || (w_out_last && bus.out_ready);

  assign bus.data_out  = w_acc[NT];
  assign bus.out_valid = (r_state == SEND);
  assign bus.busy      = (r_state == SEND);
  assign bus.out_last  = w_out_last;
  assign bus.in_ready  = w_in_ready;

  // Capture / advance / scrub: the holding register is zeroed once a block has fully left.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_word_idx  <= '0;
      r_share_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_hold      <= w_decoded;
            r_word_idx  <= '0;
            r_share_idx <= '0;
            r_state     <= SEND;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (w_out_last) begin
              r_word_idx  <= '0;
              r_share_idx <= '0;
              if (bus.in_valid) begin
                r_hold  <= w_decoded;
                r_state <= SEND;
              end else begin
                r_hold  <= '0;
                r_state <= IDLE;
              end
            end else if (w_word_last) begin
              r_word_idx  <= '0;
              r_share_idx <= r_share_idx + SIW'(1);
            end else begin
              r_word_idx  <= r_word_idx + WIW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msk_shares_serializer.sv
// Self-checking bench for msk_shares_serializer (d=2, BITS=128, WORD=32).
// Table vectors plus random blocks against a share/word slicing model; hand sequences for back-to-back and reset.
module tb_msk_shares_serializer;

  localparam int D = 2, BITS = 128, WORD = 32, NT = 8;

  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;

  msk_shares_serializer_if #(.d(D), .BITS(BITS), .WORD(WORD)) bus ();
  msk_shares_serializer #(.d(D), .BITS(BITS), .WORD(WORD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;
  int drop_at = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic [127:0] s0;
    logic [127:0] s1;
    logic [31:0]  w [8];
    int           mode;
  } vec_t;
  vec_t tbl [3];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] interleave(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] r;
    for (int j = 0; j < 128; j++) begin
      r[2*j]   = a[j];
      r[2*j+1] = b[j];
    end
    return r;
  endfunction

  // Reference: share-major, low word of each share first.
  task automatic push_model(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] sh [2];
    sh[0] = a;
    sh[1] = b;
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 4; w++)
        exp_q.push_back(sh[i][w*32 +: 32]);
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic check_idle(input string tag);
    #1;
    chk({tag, ".out_valid"}, 256'(bus.out_valid), 256'(0));
    chk({tag, ".busy"},      256'(bus.busy),      256'(0));
    chk({tag, ".out_last"},  256'(bus.out_last),  256'(0));
    chk({tag, ".in_ready"},  256'(bus.in_ready),  256'(1));
    chk({tag, ".data_out"},  256'(bus.data_out),  256'(0));
    chk({tag, ".hold"},      256'(dut.r_hold),    256'(0));
  endtask

  // Called at a negedge with the DUT idle; in_valid stays high if keep is set.
  task automatic start_block(input logic [127:0] a, input logic [127:0] b, input bit keep);
    #1;
    chk("start.in_ready", 256'(bus.in_ready), 256'(1));
    bus.sh_data_in = interleave(a, b);
    bus.in_valid   = 1'b1;
    @(negedge clk);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  // Consume exp_q; mode 3 also asserts in_valid with junk data during every stall.
  task automatic stream(input int mode);
    int k = 0;
    int cyc = 0;
    int n = exp_q.size();
    bit stalled = 0;
    logic [31:0] pd = '0;
    logic pl = 0;
    logic rdy;
    logic [255:0] junk;
    while (k < n && cyc < 400) begin
      if (k >= drop_at) bus.in_valid = 1'b0;
      rdy = pick_ready(mode, cyc);
      if (mode == 3) begin
        for (int q = 0; q < 8; q++) junk[q*32 +: 32] = $urandom;
        bus.sh_data_in = junk;
        bus.in_valid   = ~rdy;
      end
      bus.out_ready = rdy;
      #1;
      chk("out_valid", 256'(bus.out_valid), 256'(1));
      chk("busy",      256'(bus.busy),      256'(1));
      if (stalled) begin
        chk("stall.data_out", 256'(bus.data_out), 256'(pd));
        chk("stall.out_last", 256'(bus.out_last), 256'(pl));
      end
      if (rdy) begin
        chk($sformatf("word%0d", k), 256'(bus.data_out), 256'(exp_q[k]));
        chk($sformatf("last%0d", k), 256'(bus.out_last), 256'(k % NT == NT-1));
        chk($sformatf("in_ready%0d", k), 256'(bus.in_ready), 256'(k % NT == NT-1));
        k++;
        stalled = 0;
      end else begin
        chk("stall.in_ready", 256'(bus.in_ready), 256'(0));
        stalled = 1;
        pd = bus.data_out;
        pl = bus.out_last;
      end
      @(negedge clk);
      cyc++;
    end
    if (k < n) begin
      n_fail++;
      $display("FAIL stream timeout: got %0d words expected %0d", k, n);
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [127:0] a, b;
    bus.sh_data_in = '0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;

    tbl[0].s0 = 128'h00112233_44556677_8899aabb_ccddeeff;
    tbl[0].s1 = 128'hfedcba98_76543210_0f1e2d3c_4b5a6978;
    tbl[0].w  = '{32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233,
                  32'h4b5a6978, 32'h0f1e2d3c, 32'h76543210, 32'hfedcba98};
    tbl[0].mode = 0;
    tbl[1] = tbl[0];
    tbl[1].mode = 1;
    tbl[2].s0 = 128'hdeadbeef_01234567_89abcdef_a5a5a5a5;
    tbl[2].s1 = 128'h00000000_ffffffff_13579bdf_2468ace0;
    tbl[2].w  = '{32'ha5a5a5a5, 32'h89abcdef, 32'h01234567, 32'hdeadbeef,
                  32'h2468ace0, 32'h13579bdf, 32'hffffffff, 32'h00000000};
    tbl[2].mode = 2;

    // Reset held, then released.
    @(negedge clk);
    @(negedge clk);
    check_idle("rst_held");
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_done");

    // Table vectors: straight, 1,0,0,1 stall pattern, random stalls.
    for (int t = 0; t < 3; t++) begin
      for (int w = 0; w < 8; w++) exp_q.push_back(tbl[t].w[w]);
      drop_at = 0;
      start_block(tbl[t].s0, tbl[t].s1, 0);
      stream(tbl[t].mode);
      check_idle($sformatf("tbl%0d_end", t));
    end

    // Ignored input: junk in_valid during stalls must not disturb the stream.
    push_model(tbl[2].s0, tbl[2].s1);
    drop_at = 0;
    start_block(tbl[2].s0, tbl[2].s1, 0);
    stream(3);
    check_idle("ignored_end");

    // Back-to-back: A with in_valid held, then B presented; B taken on A's last handshake.
    push_model(tbl[0].s0, tbl[0].s1);
    push_model(tbl[2].s0, tbl[2].s1);
    drop_at = NT;
    start_block(tbl[0].s0, tbl[0].s1, 1);
    bus.sh_data_in = interleave(tbl[2].s0, tbl[2].s1);
    stream(0);
    check_idle("b2b_end");

    // Reset after three words, then a fresh block from word 0.
    drop_at = 0;
    start_block(tbl[2].s0, tbl[2].s1, 0);
    bus.out_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      #1;
      chk($sformatf("pre_rst_word%0d", w), 256'(bus.data_out), 256'(tbl[2].w[w]));
      @(negedge clk);
    end
    rst = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_idle("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_rst");
    push_model(tbl[0].s0, tbl[0].s1);
    start_block(tbl[0].s0, tbl[0].s1, 0);
    stream(0);
    check_idle("restart_end");

    // Random blocks against the model.
    for (int r = 0; r < 10; r++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      push_model(a, b);
      drop_at = 0;
      start_block(a, b, 0);
      stream(int'($urandom_range(0, 3)));
      check_idle($sformatf("rnd%0d_end", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
